// File: rtl/wb_mux.sv
// Write-back selector: picks the register-file write data from ALU, load data, PC+4 or immediate.
// Optional load-timeout watchdog enabled by defining WB_TIMEOUT_EN.
module wb_mux #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_reg_write,
    input  logic [RD_W-1:0] ex_rd,
    input  logic [1:0]      ex_wb_src,
    input  logic [XLEN-1:0] ex_alu_res,
    input  logic [XLEN-1:0] ex_pc4,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [2:0]      ex_funct3,
    input  logic [1:0]      ex_addr_lo,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rf_we,
    output logic [RD_W-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            stall,
    output logic            wb_err
);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_PC4 = 2'b10;
    localparam logic [1:0] SRC_IMM = 2'b11;

    state_t            state, state_next;
    logic [RD_W-1:0]   pend_rd;
    logic              pend_we;
    logic [2:0]        pend_f3;
    logic [1:0]        pend_lo;

    logic              capture;
    logic              do_write;
    logic              wr_reg;
    logic [RD_W-1:0]   wr_addr;
    logic [XLEN-1:0]   wr_data;
    logic              wr_commit;
    logic              set_err;

    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3,
                                                 input logic [1:0] lo,
                                                 input logic [XLEN-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b100:  load_ext = {24'b0, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b101:  load_ext = {16'b0, h};
            default: load_ext = w;
        endcase
    endfunction

    assign ex_ready = (state == IDLE);
    assign stall    = ~ex_ready;

`ifdef WB_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       timeout;

    // The count reaches 255 on the edge that ends the 255th waiting cycle.
    assign timeout = (state == WAIT_MEM) && !mem_rvalid && (wait_cnt == 8'd254);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
            wb_err   <= 1'b0;
        end else begin
            if (capture)
                wait_cnt <= '0;
            else if (state == WAIT_MEM)
                wait_cnt <= wait_cnt + 8'd1;
            if (set_err)
                wb_err <= 1'b1;
        end
    end
`else
    logic timeout;
    assign timeout = 1'b0;
    assign wb_err  = 1'b0;
`endif

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        do_write   = 1'b0;
        wr_reg     = 1'b0;
        wr_addr    = ex_rd;
        wr_data    = '0;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_wb_src == SRC_MEM) begin
                        capture    = 1'b1;
                        state_next = WAIT_MEM;
                    end else begin
                        do_write = 1'b1;
                        wr_reg   = ex_reg_write;
                        case (ex_wb_src)
                            SRC_PC4: wr_data = ex_pc4;
                            SRC_IMM: wr_data = ex_imm;
                            default: wr_data = ex_alu_res;
                        endcase
                    end
                end
            end
            WAIT_MEM: begin
                wr_addr = pend_rd;
                wr_reg  = pend_we;
                if (mem_rvalid) begin
                    do_write   = 1'b1;
                    wr_data    = load_ext(pend_f3, pend_lo, mem_rdata);
                    state_next = IDLE;
                end else if (timeout) begin
                    do_write   = 1'b1;
                    set_err    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign wr_commit = do_write && wr_reg && (wr_addr != '0);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            state <= state_next;
            rf_we <= wr_commit;
            if (wr_commit) begin
                rf_waddr <= wr_addr;
                rf_wdata <= wr_data;
            end
        end
    end

    // NOTE: pending-load fields are only read in WAIT_MEM after a capture, so they need no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            pend_rd <= ex_rd;
            pend_we <= ex_reg_write;
            pend_f3 <= ex_funct3;
            pend_lo <= ex_addr_lo;
        end
    end

    // Sources other than MEM are fully decoded above; keep the names referenced.
    logic unused_src;
    assign unused_src = (SRC_ALU == SRC_IMM);

endmodule

// File: tb/tb_wb_mux.sv
// Directed self-checking bench for wb_mux; covers reset, ALU/PC+4/IMM writes, loads and reset mid-load.
// Define WB_TIMEOUT_EN to also exercise the load-timeout watchdog.
module tb_wb_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_reg_write;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_wb_src;
    logic [31:0] ex_alu_res, ex_pc4, ex_imm;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall;
    logic        wb_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    wb_mux dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .ex_wb_src(ex_wb_src),
        .ex_alu_res(ex_alu_res), .ex_pc4(ex_pc4), .ex_imm(ex_imm),
        .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall(stall), .wb_err(wb_err)
    );

    // Advance to 1 ns after the next rising edge: outputs are sampled and inputs driven there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0; ex_wb_src = 2'b00;
        ex_alu_res = 32'h0; ex_pc4 = 32'h0; ex_imm = 32'h0;
        ex_funct3 = 3'b000; ex_addr_lo = 2'b00;
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic check_write(input string tag, input logic we, input logic [4:0] addr,
                               input logic [31:0] data);
        total_cnt++;
        if (rf_we !== we) $display("FAIL %s rf_we got %b want %b", tag, rf_we, we);
        else pass_cnt++;
        total_cnt++;
        if (rf_waddr !== addr) $display("FAIL %s rf_waddr got %0d want %0d", tag, rf_waddr, addr);
        else pass_cnt++;
        total_cnt++;
        if (rf_wdata !== data) $display("FAIL %s rf_wdata got %h want %h", tag, rf_wdata, data);
        else pass_cnt++;
    endtask

    task automatic check_ready(input string tag, input logic rdy);
        total_cnt++;
        if (ex_ready !== rdy || stall !== ~rdy)
            $display("FAIL %s ready/stall got %b/%b want %b/%b", tag, ex_ready, stall, rdy, ~rdy);
        else pass_cnt++;
    endtask

    task automatic check_err(input string tag, input logic err);
        total_cnt++;
        if (wb_err !== err) $display("FAIL %s wb_err got %b want %b", tag, wb_err, err);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        check_write("reset_low", 1'b0, 5'd0, 32'h0);
        check_ready("reset_low", 1'b1);
        check_err("reset_low", 1'b0);
        reset = 1'b1;
        step();
        check_write("reset_rel", 1'b0, 5'd0, 32'h0);
        check_ready("reset_rel", 1'b1);
    endtask

    task automatic test_back_to_back();
        ex_valid = 1'b1; ex_reg_write = 1'b1; ex_wb_src = 2'b00;
        ex_rd = 5'd5; ex_alu_res = 32'h0000_1234;
        check_ready("b2b_pre", 1'b1);
        step();
        check_write("b2b_x5", 1'b1, 5'd5, 32'h0000_1234);
        check_ready("b2b_x5", 1'b1);
        ex_rd = 5'd6; ex_alu_res = 32'hFFFF_0000;
        step();
        check_write("b2b_x6", 1'b1, 5'd6, 32'hFFFF_0000);
        check_ready("b2b_x6", 1'b1);
        idle_inputs();
        step();
        check_write("b2b_after", 1'b0, 5'd6, 32'hFFFF_0000);
    endtask

    // Load accepted, response three cycles later; an early pulse in the acceptance cycle must be ignored.
    task automatic test_load(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                             input logic early_pulse, input logic [31:0] expect_val);
        ex_valid = 1'b1; ex_reg_write = 1'b1; ex_wb_src = 2'b01;
        ex_rd = 5'd7; ex_funct3 = f3; ex_addr_lo = lo; ex_alu_res = 32'h0000_1003;
        mem_rvalid = early_pulse; mem_rdata = 32'h1111_1111;
        step();
        idle_inputs();
        for (int c = 1; c <= 3; c++) begin
            check_ready($sformatf("%s_stall%0d", tag, c), 1'b0);
            total_cnt++;
            if (rf_we !== 1'b0) $display("FAIL %s_nowr%0d rf_we got %b want 0", tag, c, rf_we);
            else pass_cnt++;
            if (c == 3) begin
                mem_rvalid = 1'b1; mem_rdata = 32'h80AB_CD12;
            end
            step();
        end
        idle_inputs();
        check_write(tag, 1'b1, 5'd7, expect_val);
        check_ready({tag, "_done"}, 1'b1);
    endtask

    task automatic test_x0_and_pc4();
        ex_valid = 1'b1; ex_reg_write = 1'b1; ex_wb_src = 2'b11;
        ex_rd = 5'd0; ex_imm = 32'h0000_5000;
        step();
        total_cnt++;
        if (rf_we !== 1'b0) $display("FAIL imm_x0 rf_we got %b want 0", rf_we);
        else pass_cnt++;
        ex_wb_src = 2'b10; ex_rd = 5'd1; ex_pc4 = 32'h0000_0104; ex_imm = 32'hDEAD_BEEF;
        ex_alu_res = 32'hCAFE_0000;
        step();
        check_write("pc4_x1", 1'b1, 5'd1, 32'h0000_0104);
        ex_reg_write = 1'b0; ex_wb_src = 2'b11; ex_rd = 5'd3;
        step();
        check_write("nowrite", 1'b0, 5'd1, 32'h0000_0104);
        idle_inputs();
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        idle_inputs();
        check_write("idle_rvalid", 1'b0, 5'd1, 32'h0000_0104);
        check_ready("idle_rvalid", 1'b1);
    endtask

    task automatic test_reset_mid_load();
        ex_valid = 1'b1; ex_reg_write = 1'b1; ex_wb_src = 2'b01;
        ex_rd = 5'd7; ex_funct3 = 3'b010; ex_addr_lo = 2'b00;
        step();
        idle_inputs();
        check_ready("rml_wait", 1'b0);
        reset = 1'b0;
        step();
        check_ready("rml_rst", 1'b1);
        reset = 1'b1;
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_5555;
        step();
        idle_inputs();
        check_write("rml_late", 1'b0, 5'd0, 32'h0);
        check_ready("rml_late", 1'b1);
    endtask

    task automatic test_timeout();
`ifdef WB_TIMEOUT_EN
        int cycles;
        ex_valid = 1'b1; ex_reg_write = 1'b1; ex_wb_src = 2'b01;
        ex_rd = 5'd9; ex_funct3 = 3'b010;
        step();
        idle_inputs();
        cycles = 0;
        while (stall === 1'b1 && cycles < 300) begin
            step();
            cycles++;
        end
        total_cnt++;
        if (cycles != 255) $display("FAIL to_cycles got %0d want 255", cycles);
        else pass_cnt++;
        check_write("to_x9", 1'b1, 5'd9, 32'h0);
        check_err("to_set", 1'b1);
        ex_valid = 1'b1; ex_reg_write = 1'b1; ex_wb_src = 2'b00; ex_rd = 5'd4;
        ex_alu_res = 32'h0000_0044;
        step();
        idle_inputs();
        step();
        check_err("to_sticky", 1'b1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_err("to_clr", 1'b0);
`else
        ex_valid = 1'b1; ex_reg_write = 1'b1; ex_wb_src = 2'b01;
        ex_rd = 5'd9; ex_funct3 = 3'b010;
        step();
        idle_inputs();
        repeat (270) step();
        check_ready("nt_wait", 1'b0);
        check_err("nt_err", 1'b0);
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
        step();
        idle_inputs();
        check_write("nt_x9", 1'b1, 5'd9, 32'h0BAD_F00D);
`endif
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_back_to_back();
        test_load("lb",  3'b000, 2'd3, 1'b0, 32'hFFFF_FF80);
        test_load("lbu", 3'b100, 2'd3, 1'b1, 32'h0000_0080);
        test_load("lh",  3'b001, 2'd2, 1'b0, 32'hFFFF_80AB);
        test_load("lhu", 3'b101, 2'd0, 1'b0, 32'h0000_CD12);
        test_load("lw",  3'b010, 2'd3, 1'b0, 32'h80AB_CD12);
        test_load("lb1", 3'b000, 2'd0, 1'b0, 32'h0000_0012);
        test_x0_and_pc4();
        test_reset_mid_load();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
